riscv_data_responder: RTL and testbench
=======================================

# riscv_data_responder

Bus responder on the far side of the RISC-V core's instruction and data ports. It serves instruction fetches and loads/stores from on-chip RAM with one-cycle synchronous read latency. It performs the byte-lane alignment the core does not do, and hosts a memory-mapped 64-bit machine timer that drives the core's `irq` input.

## Interface
- `RAM_WORDS`, 1024: RAM depth in 32-bit words; power of two; RAM mapped at 0x0000_0000.
- `TIMER_BASE`, 32'hFFFF_0000: base of the 16-byte timer window.
- `clock` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `instruction_address` input 32: fetch byte address; only bits [31:2] are used.
- `instruction_data` output 32: fetched word, valid one cycle after the address.
- `data_address` input 32: load/store byte address; ignored (may be Z) when neither strobe is high.
- `data_width` input 2: 0 byte, 1 half, 2 word, 3 illegal.
- `data_out` input 32: store data from the core, right-aligned (byte in [7:0], half in [15:0]).
- `data_read` input 1: load request this cycle.
- `data_write` input 1: store request this cycle.
- `data_in` output 32: load result, right-aligned, upper bits zero; valid one cycle after `data_read`.
- `irq` output 1: registered timer interrupt, level.
- `bus_error` output 1: one-cycle pulse, registered, on a faulting access.

## Operation
- Decode: RAM hit when `data_address < RAM_WORDS*4`. Timer hit when `data_address[31:4] == TIMER_BASE[31:4]`. Anything else is unmapped.
- RAM store: byte at lane `addr[1:0]` takes `data_out[7:0]`. Half at lane `addr[1]*2` takes `data_out[15:0]`. Word writes all lanes. Other lanes are unchanged.
- RAM load: the selected lane(s) are shifted down to bit 0 and upper bits are zeroed. The core performs sign extension.
- Misaligned access (half with `addr[0]=1`, word with `addr[1:0]!=0`), `data_width==3`, or unmapped address:
  - no state change;
  - `data_in` = 0 next cycle;
  - `bus_error` pulses next cycle.
- Timer registers, word access only (non-word access is a fault):
  - +0x0 mtime[31:0]
  - +0x4 mtime[63:32]
  - +0x8 mtimecmp[31:0]
  - +0xC mtimecmp[63:32]
- mtime increments by 1 every cycle and wraps at 2^64. In a cycle where software writes either mtime half, the written half takes the data, the other half holds, and there is no increment.
- `irq` register <= (mtime >= mtimecmp), unsigned 64-bit, using pre-edge values.
- Both strobes high in one cycle: the store is performed, the load returns 0, and `bus_error` pulses.
- Instruction port: RAM word `instruction_address[31:2]` mod RAM_WORDS, read every cycle. Addresses outside RAM return 0 (no error; the core decodes this as an illegal opcode).

## Timing
- Reset values: `instruction_data`=0, `data_in`=0, `irq`=0, `bus_error`=0, mtime=0, mtimecmp=all ones. RAM contents are not reset.
- Load latency: request in cycle N, data on `data_in` throughout cycle N+1 from a register. `data_in` holds its value until the next load or reset.
- Store commits at the end of cycle N. A load of the same word in N+1 returns the new data; no bypass is needed.
- Fetch latency: 1 cycle. Fetch and data ports operate concurrently. A fetch of a word stored in cycle N returns old data in cycle N+1 and new data from N+2.
- `irq` lags the compare by one cycle. Writing mtimecmp above mtime clears `irq` one cycle after the write edge.
- Reset asserted mid-operation: a pending load result is discarded and outputs take reset values on the next edge.

## Structure
- Shared package `riscv_bus_pkg`:
  - width codes (BYTE/HALF/WORD);
  - timer register offsets;
  - default TIMER_BASE;
  - helper functions for lane-enable and load-alignment.
- Sub-module `riscv_ram_bank`: four byte-lane arrays, one write port with 4-bit byte enable, two synchronous read ports (data, instruction).
- Top-level contains decode, alignment, timer, irq and error registers.

## Test plan
- Store word 0x11223344 to 0x10, then load byte at 0x12 -> `data_in`=0x00000022 in the cycle after the request.
- Store half 0xBEEF (`data_out`=0xFFFFBEEF) to 0x22 over word 0xAAAAAAAA at 0x20 -> word load of 0x20 returns 0xBEEFAAAA. A fetch of 0x20 returns the same value two cycles after the store.
- Word load at 0x13, half store at 0x15, width 3 at 0x0 -> each: `bus_error` one-cycle pulse, `data_in`=0, RAM unchanged.
- Load from 0x8000_0000 (unmapped) -> `data_in`=0, `bus_error`=1 for one cycle. Instruction fetch of the same address returns 0 with no error.
- Write mtimecmp hi=0 then lo=40 -> `irq` rises exactly one cycle after mtime reads 40. Writing mtimecmp lo=0xFFFFFFFF drops `irq` the cycle after the write edge.
- Write mtime lo=0xFFFFFFFF, hi=0xFFFFFFFF -> the value wraps to 0 two cycles later. Assert `reset` during a pending load -> `data_in`=0 and `irq`=0 after the edge.

Source files
------------

// File: rtl/riscv_bus_pkg.sv
// Shared definitions for the RISC-V data/instruction responder:
// access width codes, timer register map and byte-lane helpers.
package riscv_bus_pkg;

  typedef enum logic [1:0] {
    WIDTH_BYTE    = 2'd0,
    WIDTH_HALF    = 2'd1,
    WIDTH_WORD    = 2'd2,
    WIDTH_ILLEGAL = 2'd3
  } width_e;

  // Timer registers, indexed by address bits [3:2] inside the 16-byte window.
  typedef enum logic [1:0] {
    TMR_MTIME_LO = 2'd0,
    TMR_MTIME_HI = 2'd1,
    TMR_CMP_LO   = 2'd2,
    TMR_CMP_HI   = 2'd3
  } timer_reg_e;

  typedef enum logic {
    SRC_HOLD = 1'b0,
    SRC_RAM  = 1'b1
  } load_src_e;

  localparam logic [31:0] TIMER_BASE_DEFAULT = 32'hFFFF_0000;

  function automatic logic [3:0] lane_enable(input width_e w, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (w)
      WIDTH_BYTE: be = 4'b0001 << lane;
      WIDTH_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      WIDTH_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(input width_e w, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (w)
      WIDTH_HALF: bad = lane[0];
      WIDTH_WORD: bad = (lane != 2'd0);
      default:    bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Right-aligned store data is copied onto every lane; the byte enables pick the target.
  function automatic logic [31:0] store_replicate(input width_e w, input logic [31:0] d);
    logic [31:0] r;
    case (w)
      WIDTH_BYTE: r = {4{d[7:0]}};
      WIDTH_HALF: r = {2{d[15:0]}};
      default:    r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_align(input logic [31:0] word, input width_e w,
                                             input logic [1:0] lane);
    logic [31:0] shifted;
    logic [31:0] r;
    shifted = word >> {lane, 3'b000};
    case (w)
      WIDTH_BYTE: r = {24'h0, shifted[7:0]};
      WIDTH_HALF: r = {16'h0, shifted[15:0]};
      WIDTH_WORD: r = word;
      default:    r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_ram_bank.sv
// Four byte-lane RAM arrays with a byte-enabled write port and two
// registered read ports (data and instruction), read-before-write.
module riscv_ram_bank #(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_data
);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [WORDS];
      logic [7:0] rd_data_q;
      logic [7:0] if_data_q;

      // The data read register only loads on a request so a load result persists.
      always_ff @(posedge clock) begin
        if (wr_be[gi]) begin
          mem[wr_addr] <= wr_data[8*gi +: 8];
        end
        if (rd_en) begin
          rd_data_q <= mem[rd_addr];
        end
        if_data_q <= mem[if_addr];
      end

      assign rd_data[8*gi +: 8] = rd_data_q;
      assign if_data[8*gi +: 8] = if_data_q;
    end
  endgenerate

endmodule

// File: rtl/riscv_data_responder.sv
// Bus responder for a RISC-V core: RAM-backed fetch and load/store with lane
// alignment, plus a memory-mapped 64-bit machine timer driving irq.
module riscv_data_responder
  import riscv_bus_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter logic [31:0] TIMER_BASE = TIMER_BASE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction_address,
  output logic [31:0] instruction_data,
  input  logic [31:0] data_address,
  input  logic [1:0]  data_width,
  input  logic [31:0] data_out,
  input  logic        data_read,
  input  logic        data_write,
  output logic [31:0] data_in,
  output logic        irq,
  output logic        bus_error
);

  localparam int unsigned AW        = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_LIMIT = 33'(RAM_WORDS) << 2;

  width_e      width;
  logic [1:0]  lane;
  timer_reg_e  treg;
  logic        ram_hit;
  logic        timer_hit;
  logic        access_fault;
  logic        store_ok;
  logic        load_ok;
  logic        ram_rd_en;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] if_rdata;
  logic [31:0] timer_rdata;

  load_src_e   src_q, src_d;
  width_e      ld_width_q, ld_width_d;
  logic [1:0]  ld_lane_q, ld_lane_d;
  logic [31:0] hold_q, hold_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        irq_q, irq_d;
  logic        bus_error_q, bus_error_d;
  logic        if_valid_q, if_valid_d;

  assign width = width_e'(data_width);
  assign lane  = data_address[1:0];
  assign treg  = timer_reg_e'(data_address[3:2]);

  // Decode and fault classification; everything is gated by the strobes.
  always_comb begin
    ram_hit      = ({1'b0, data_address} < RAM_LIMIT);
    timer_hit    = (data_address[31:4] == TIMER_BASE[31:4]);
    access_fault = (width == WIDTH_ILLEGAL)
                 || misaligned(width, lane)
                 || !(ram_hit || timer_hit)
                 || (timer_hit && (width != WIDTH_WORD));
    store_ok     = data_write && !access_fault;
    // A simultaneous store wins; the load half of that cycle returns zero.
    load_ok      = data_read && !data_write && !access_fault;
    ram_rd_en    = load_ok && ram_hit;
    ram_be       = (store_ok && ram_hit) ? lane_enable(width, lane) : 4'b0000;
    ram_wdata    = store_replicate(width, data_out);
    bus_error_d  = (data_read || data_write)
                 && (access_fault || (data_read && data_write));
    if_valid_d   = ({1'b0, instruction_address} < RAM_LIMIT);
  end

  riscv_ram_bank #(
    .WORDS (RAM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clock   (clock),
    .wr_be   (ram_be),
    .wr_addr (data_address[AW+1:2]),
    .wr_data (ram_wdata),
    .rd_en   (ram_rd_en),
    .rd_addr (data_address[AW+1:2]),
    .rd_data (ram_rdata),
    .if_addr (instruction_address[AW+1:2]),
    .if_data (if_rdata)
  );

  always_comb begin
    timer_rdata = 32'h0;
    case (treg)
      TMR_MTIME_LO: timer_rdata = mtime_q[31:0];
      TMR_MTIME_HI: timer_rdata = mtime_q[63:32];
      TMR_CMP_LO:   timer_rdata = mtimecmp_q[31:0];
      TMR_CMP_HI:   timer_rdata = mtimecmp_q[63:32];
      default:      timer_rdata = 32'h0;
    endcase
  end

  // Software writes to either mtime half suppress that cycle's increment.
  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    if (store_ok && timer_hit) begin
      case (treg)
        TMR_MTIME_LO: mtime_d    = {mtime_q[63:32], data_out};
        TMR_MTIME_HI: mtime_d    = {data_out, mtime_q[31:0]};
        TMR_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32], data_out};
        TMR_CMP_HI:   mtimecmp_d = {data_out, mtimecmp_q[31:0]};
        default:      mtimecmp_d = mtimecmp_q;
      endcase
    end
    irq_d = (mtime_q >= mtimecmp_q);
  end

  // RAM loads are aligned on the way out of the read register; timer reads
  // and faulted loads are captured directly into the hold register.
  always_comb begin
    src_d      = src_q;
    ld_width_d = ld_width_q;
    ld_lane_d  = ld_lane_q;
    hold_d     = hold_q;
    if (data_read) begin
      if (ram_rd_en) begin
        src_d      = SRC_RAM;
        ld_width_d = width;
        ld_lane_d  = lane;
      end else begin
        src_d  = SRC_HOLD;
        hold_d = load_ok ? timer_rdata : 32'h0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      src_q       <= SRC_HOLD;
      ld_width_q  <= WIDTH_WORD;
      ld_lane_q   <= 2'd0;
      hold_q      <= 32'h0;
      mtime_q     <= 64'h0;
      mtimecmp_q  <= '1;
      irq_q       <= 1'b0;
      bus_error_q <= 1'b0;
      if_valid_q  <= 1'b0;
    end else begin
      src_q       <= src_d;
      ld_width_q  <= ld_width_d;
      ld_lane_q   <= ld_lane_d;
      hold_q      <= hold_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      irq_q       <= irq_d;
      bus_error_q <= bus_error_d;
      if_valid_q  <= if_valid_d;
    end
  end

  assign data_in          = (src_q == SRC_RAM) ? load_align(ram_rdata, ld_width_q, ld_lane_q)
                                               : hold_q;
  assign instruction_data = if_valid_q ? if_rdata : 32'h0;
  assign irq              = irq_q;
  assign bus_error        = bus_error_q;

endmodule

// File: tb/tb_riscv_data_responder.sv
// Self-checking bench for riscv_data_responder: directed vector table,
// timer/reset sequences and randomized traffic against a byte-level model.
module tb_riscv_data_responder;

  localparam int unsigned RAM_WORDS = 1024;
  localparam int unsigned RAM_BYTES = RAM_WORDS * 4;
  localparam logic [31:0] TB_BASE   = 32'hFFFF_0000;
  localparam logic [31:0] UNMAPPED  = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction_address;
  logic [31:0] instruction_data;
  logic [31:0] data_address;
  logic [1:0]  data_width;
  logic [31:0] data_out;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_in;
  logic        irq;
  logic        bus_error;

  riscv_data_responder #(
    .RAM_WORDS  (RAM_WORDS),
    .TIMER_BASE (TB_BASE)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .instruction_address (instruction_address),
    .instruction_data    (instruction_data),
    .data_address        (data_address),
    .data_width          (data_width),
    .data_out            (data_out),
    .data_read           (data_read),
    .data_write          (data_write),
    .data_in             (data_in),
    .irq                 (irq),
    .bus_error           (bus_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: byte-addressed memory and plain 64-bit timer values.
  bit   [7:0]  mem_m [RAM_BYTES];
  logic [63:0] mtime_m;
  logic [63:0] cmp_m;
  logic [31:0] exp_din;
  logic [31:0] exp_if;
  logic        exp_irq;
  logic        exp_err;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  w;
    logic [31:0] wd;
    logic [31:0] ia;
    logic [31:0] din;
    logic [31:0] ifd;
    bit          err;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit rd, input bit wr, input logic [31:0] a,
                            input logic [1:0] w, input logic [31:0] wd, input logic [31:0] ia);
    int unsigned nb;
    int unsigned base;
    bit          in_ram;
    bit          in_tmr;
    bit          fault;
    bit          mtime_written;
    logic [31:0] v;
    if (rst) begin
      mtime_m = 64'h0;
      cmp_m   = '1;
      exp_din = 32'h0;
      exp_if  = 32'h0;
      exp_irq = 1'b0;
      exp_err = 1'b0;
      return;
    end
    in_ram = (a < RAM_BYTES);
    in_tmr = (a[31:4] == TB_BASE[31:4]);
    nb     = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    fault  = (w == 2'd3) || ((a % nb) != 0) || !(in_ram || in_tmr) || (in_tmr && w != 2'd2);
    if (ia < RAM_BYTES) begin
      base   = ia & 32'hFFFF_FFFC;
      exp_if = {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
    end else begin
      exp_if = 32'h0;
    end
    exp_irq = (mtime_m >= cmp_m);
    exp_err = (rd || wr) && (fault || (rd && wr));
    if (rd) begin
      if (fault || wr) begin
        exp_din = 32'h0;
      end else if (in_ram) begin
        v = 32'h0;
        for (int i = 0; i < int'(nb); i++) v = v | (32'(mem_m[a+i]) << (8 * i));
        exp_din = v;
      end else begin
        case (a[3:2])
          2'd0:    exp_din = mtime_m[31:0];
          2'd1:    exp_din = mtime_m[63:32];
          2'd2:    exp_din = cmp_m[31:0];
          default: exp_din = cmp_m[63:32];
        endcase
      end
    end
    mtime_written = 1'b0;
    if (wr && !fault) begin
      if (in_ram) begin
        for (int i = 0; i < int'(nb); i++) mem_m[a+i] = wd[8*i +: 8];
      end else begin
        case (a[3:2])
          2'd0:    begin mtime_m[31:0]  = wd; mtime_written = 1'b1; end
          2'd1:    begin mtime_m[63:32] = wd; mtime_written = 1'b1; end
          2'd2:    cmp_m[31:0]  = wd;
          default: cmp_m[63:32] = wd;
        endcase
      end
    end
    if (!mtime_written) mtime_m = mtime_m + 64'd1;
  endtask

  // One bus cycle: drive, predict, clock, then compare all outputs #1 after the edge.
  task automatic do_cycle(input bit rst, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [1:0] w, input logic [31:0] wd, input logic [31:0] ia,
                          input string tag);
    reset               = rst;
    data_read           = rd;
    data_write          = wr;
    data_address        = a;
    data_width          = w;
    data_out            = wd;
    instruction_address = ia;
    model_step(rst, rd, wr, a, w, wd, ia);
    @(posedge clock);
    #1;
    $display("%s rst=%0d rd=%0d wr=%0d a=%08h w=%0d wd=%08h ia=%08h -> din=%08h err=%0d irq=%0d if=%08h",
             tag, rst, rd, wr, a, w, wd, ia, data_in, bus_error, irq, instruction_data);
    check({tag, " data_in"}, data_in, exp_din);
    check({tag, " bus_error"}, 32'(bus_error), 32'(exp_err));
    check({tag, " irq"}, 32'(irq), 32'(exp_irq));
    check({tag, " instruction_data"}, instruction_data, exp_if);
  endtask

  initial begin
    bit          found;
    logic        prev_irq;
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] ia;
    int unsigned sel;

    vecs[0]  = '{1'b0, 1'b1, 32'h10,     2'd2, 32'h11223344, UNMAPPED, 32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h12,     2'd0, 32'h0,        UNMAPPED, 32'h22,       32'h0,        1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h14,     2'd2, 32'h0BADF00D, UNMAPPED, 32'h22,       32'h0,        1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h00,     2'd2, 32'hCAFEBABE, UNMAPPED, 32'h22,       32'h0,        1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h20,     2'd2, 32'hAAAAAAAA, UNMAPPED, 32'h22,       32'h0,        1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h22,     2'd1, 32'hFFFFBEEF, 32'h20,   32'h22,       32'hAAAAAAAA, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h20,     2'd2, 32'h0,        32'h20,   32'hBEEFAAAA, 32'hBEEFAAAA, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h13,     2'd2, 32'h0,        UNMAPPED, 32'h0,        32'h0,        1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,      2'd0, 32'h0,        UNMAPPED, 32'h0,        32'h0,        1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h15,     2'd1, 32'h00005555, UNMAPPED, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b0, 1'b1, 32'h00,     2'd3, 32'h12345678, UNMAPPED, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'h14,     2'd2, 32'h0,        UNMAPPED, 32'h0BADF00D, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h00,     2'd2, 32'h0,        UNMAPPED, 32'hCAFEBABE, 32'h0,        1'b0};
    vecs[13] = '{1'b1, 1'b0, UNMAPPED,   2'd2, 32'h0,        UNMAPPED, 32'h0,        32'h0,        1'b1};
    vecs[14] = '{1'b1, 1'b0, 32'h12,     2'd1, 32'h0,        UNMAPPED, 32'h1122,     32'h0,        1'b0};
    vecs[15] = '{1'b0, 1'b1, 32'hFFC,    2'd2, 32'h89ABCDEF, UNMAPPED, 32'h1122,     32'h0,        1'b0};
    vecs[16] = '{1'b1, 1'b0, 32'hFFF,    2'd0, 32'h0,        UNMAPPED, 32'h89,       32'h0,        1'b0};
    vecs[17] = '{1'b1, 1'b0, 32'h1000,   2'd2, 32'h0,        UNMAPPED, 32'h0,        32'h0,        1'b1};
    vecs[18] = '{1'b1, 1'b0, 32'hFFC,    2'd2, 32'h0,        32'hFFC,  32'h89ABCDEF, 32'h89ABCDEF, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 32'h10,     2'd2, 32'h01020304, UNMAPPED, 32'h0,        32'h0,        1'b1};
    vecs[20] = '{1'b1, 1'b0, 32'h10,     2'd2, 32'h0,        UNMAPPED, 32'h01020304, 32'h0,        1'b0};
    vecs[21] = '{1'b1, 1'b0, 32'h23,     2'd0, 32'h0,        UNMAPPED, 32'hBE,       32'h0,        1'b0};
    vecs[22] = '{1'b1, 1'b0, TB_BASE,    2'd1, 32'h0,        UNMAPPED, 32'h0,        32'h0,        1'b1};

    do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, UNMAPPED, "reset0");
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, UNMAPPED, "reset1");

    for (int i = 0; i < 64; i++) begin
      do_cycle(1'b0, 1'b0, 1'b1, 32'(i * 4), 2'd2, (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5,
               UNMAPPED, $sformatf("init%0d", i));
    end

    foreach (vecs[i]) begin
      do_cycle(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].w, vecs[i].wd, vecs[i].ia,
               $sformatf("vec%0d", i));
      check($sformatf("vec%0d table data_in", i), data_in, vecs[i].din);
      check($sformatf("vec%0d table bus_error", i), 32'(bus_error), 32'(vecs[i].err));
      check($sformatf("vec%0d table instruction_data", i), instruction_data, vecs[i].ifd);
    end

    // irq rises one cycle after mtime passes through the compare value.
    do_cycle(1'b0, 1'b0, 1'b1, TB_BASE + 32'h0, 2'd2, 32'h0, UNMAPPED, "mtime_lo=0");
    do_cycle(1'b0, 1'b0, 1'b1, TB_BASE + 32'hC, 2'd2, 32'h0, UNMAPPED, "cmp_hi=0");
    do_cycle(1'b0, 1'b0, 1'b1, TB_BASE + 32'h8, 2'd2, 32'd40, UNMAPPED, "cmp_lo=40");
    prev_irq = irq;
    found    = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      do_cycle(1'b0, 1'b1, 1'b0, TB_BASE + 32'h0, 2'd2, 32'h0, UNMAPPED, "poll_mtime");
      if (data_in == 32'd40) begin
        found = 1'b1;
        check("irq at mtime 40", 32'(irq), 32'd1);
        check("irq before mtime 40", 32'(prev_irq), 32'd0);
      end
      prev_irq = irq;
    end
    check("mtime reached 40", 32'(found), 32'd1);

    do_cycle(1'b0, 1'b0, 1'b1, TB_BASE + 32'h8, 2'd2, 32'hFFFFFFFF, UNMAPPED, "cmp_lo=max");
    check("irq still set at write edge", 32'(irq), 32'd1);
    do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, UNMAPPED, "idle");
    check("irq cleared after cmp write", 32'(irq), 32'd0);

    do_cycle(1'b0, 1'b0, 1'b1, TB_BASE + 32'h0, 2'd2, 32'hFFFFFFFF, UNMAPPED, "mtime_lo=max");
    do_cycle(1'b0, 1'b0, 1'b1, TB_BASE + 32'h4, 2'd2, 32'hFFFFFFFF, UNMAPPED, "mtime_hi=max");
    do_cycle(1'b0, 1'b1, 1'b0, TB_BASE + 32'h4, 2'd2, 32'h0, UNMAPPED, "rd_mtime_hi");
    check("mtime hi before wrap", data_in, 32'hFFFFFFFF);
    do_cycle(1'b0, 1'b1, 1'b0, TB_BASE + 32'h0, 2'd2, 32'h0, UNMAPPED, "rd_mtime_lo");
    check("mtime lo after wrap", data_in, 32'h0);
    do_cycle(1'b0, 1'b1, 1'b0, TB_BASE + 32'h4, 2'd2, 32'h0, UNMAPPED, "rd_mtime_hi");
    check("mtime hi after wrap", data_in, 32'h0);

    // Reset arriving with a load in flight.
    do_cycle(1'b0, 1'b0, 1'b1, TB_BASE + 32'h8, 2'd2, 32'h0, UNMAPPED, "cmp_lo=0");
    do_cycle(1'b0, 1'b0, 1'b1, TB_BASE + 32'hC, 2'd2, 32'h0, UNMAPPED, "cmp_hi=0");
    do_cycle(1'b0, 1'b1, 1'b0, 32'h14, 2'd2, 32'h0, UNMAPPED, "load_before_reset");
    check("irq high before reset", 32'(irq), 32'd1);
    do_cycle(1'b1, 1'b1, 1'b0, 32'h10, 2'd2, 32'h0, UNMAPPED, "reset_with_load");
    check("data_in after reset", data_in, 32'h0);
    check("irq after reset", 32'(irq), 32'd0);
    do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, UNMAPPED, "post_reset");

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      rd  = 1'($urandom_range(0, 1));
      wr  = ($urandom_range(0, 3) == 0);
      if (sel < 7)      a = 32'($urandom_range(0, 255));
      else if (sel < 9) a = TB_BASE + 32'($urandom_range(0, 15));
      else              a = 32'h4000_0000 | 32'($urandom);
      if ($urandom_range(0, 7) == 0) ia = UNMAPPED + 32'($urandom_range(0, 255));
      else                           ia = 32'($urandom_range(0, 255));
      do_cycle(1'b0, rd, wr, a, 2'($urandom_range(0, 3)), 32'($urandom), ia,
               $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
